// File: rtl/sum_job_arbiter.sv
// Round-robin job sequencer that shares one sum-accumulate datapath among NREQ requesters.
// Grants one job at a time, strobes the datapath and returns the sum tagged with the requester id.
module sum_job_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 7,
    parameter int RES_W = 13,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CNT_W-1:0]   req_limit,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_result,
    output logic [CNT_W-1:0]        dp_limit,
    output logic                    ld_sum,
    output logic                    ld_counter,
    output logic                    en_sum,
    output logic                    en_counter,
    input  logic                    done,
    input  logic [RES_W-1:0]        result
);

    localparam int SW = ID_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    rr_reg, rr_next;
    logic [ID_W-1:0]    id_reg, id_next;
    logic [CNT_W-1:0]   limit_reg, limit_next;
    logic [ID_W-1:0]    rsp_id_reg, rsp_id_next;
    logic [RES_W-1:0]   rsp_result_reg, rsp_result_next;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [CNT_W-1:0]   limit_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign limit_arr[gi] = req_limit[gi*CNT_W +: CNT_W];
            assign ack[gi]       = (state_reg == GRANT) && (id_reg == ID_W'(gi));
        end
    endgenerate

    // Scan downward so the lowest offset from the rr pointer is the last (winning) assignment.
    always_comb begin
        logic [SW-1:0] scan_sum;
        logic [ID_W-1:0] scan_idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_reg} + SW'(k);
            if (scan_sum >= SW'(NREQ)) begin
                scan_sum = scan_sum - SW'(NREQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_next         = rr_reg;
        id_next         = id_reg;
        limit_next      = limit_reg;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    id_next    = pick_id;
                    limit_next = limit_arr[pick_id];
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // A zero-length job never touches the datapath.
                if (limit_reg == '0) begin
                    rsp_id_next     = id_reg;
                    rsp_result_next = '0;
                    state_next      = RESP;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: state_next = RUN;
            RUN: begin
                if (done) begin
                    rsp_id_next     = id_reg;
                    rsp_result_next = result;
                    state_next      = RESP;
                end
            end
            RESP: begin
                rr_next    = (id_reg == ID_W'(NREQ - 1)) ? '0 : id_reg + ID_W'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            rr_reg         <= '0;
            id_reg         <= '0;
            limit_reg      <= '0;
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rr_reg         <= rr_next;
            id_reg         <= id_next;
            limit_reg      <= limit_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign dp_limit   = limit_reg;
    assign ld_sum     = (state_reg == LOAD);
    assign ld_counter = (state_reg == LOAD);
    assign en_sum     = (state_reg == RUN) && !done;
    assign en_counter = (state_reg == RUN) && !done;

endmodule

// File: tb/tb_sum_job_arbiter.sv
// Bench for sum_job_arbiter: behavioural datapath, job-timeline reference model checked every
// cycle, and directed jobs with hand-computed results and latencies.
module tb_sum_job_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 7;
    localparam int RES_W = 13;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CNT_W-1:0] req_limit = '0;
    logic [NREQ-1:0]       ack;
    logic                  busy, rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [RES_W-1:0]      rsp_result;
    logic [CNT_W-1:0]      dp_limit;
    logic                  ld_sum, ld_counter, en_sum, en_counter;
    logic                  done;
    logic [RES_W-1:0]      result;

    int n_tests = 0;
    int n_fail  = 0;

    sum_job_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .RES_W(RES_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_limit(req_limit), .ack(ack), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .dp_limit(dp_limit),
        .ld_sum(ld_sum), .ld_counter(ld_counter), .en_sum(en_sum), .en_counter(en_counter),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Datapath stand-in; the counter is one bit wider so L=127 can terminate.
    logic [CNT_W:0]   dp_cnt = '0;
    logic [RES_W-1:0] dp_sum = '0;
    always @(posedge clk) begin
        if (ld_sum) dp_sum <= '0;
        else if (en_sum) dp_sum <= dp_sum + RES_W'(dp_cnt);
        if (ld_counter) dp_cnt <= 1;
        else if (en_counter) dp_cnt <= dp_cnt + 1'b1;
    end
    assign done   = dp_cnt > {1'b0, dp_limit};
    assign result = dp_sum;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tri_sum(int l);
        return l * (l + 1) / 2;
    endfunction

    function automatic int resp_off(int l);
        return (l == 0) ? 2 : l + 4;
    endfunction

    // Job-timeline model: a job starts at the edge that samples req; every output is a
    // function of the offset from that edge.
    int cyc, m_t0, m_id, m_L, m_dp, m_rr, m_prev_id, m_prev_res;
    bit m_job;
    always @(posedge clk or negedge rst) begin
        int rrv, pick, idx;
        if (!rst) begin
            cyc <= 0; m_job <= 0; m_t0 <= 0; m_id <= 0; m_L <= 0; m_dp <= 0;
            m_rr <= 0; m_prev_id <= 0; m_prev_res <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!m_job || (cyc - m_t0 >= resp_off(m_L) + 1)) begin
                rrv  = m_job ? (m_id + 1) % NREQ : m_rr;
                pick = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (rrv + k) % NREQ;
                    if (pick < 0 && ((req >> idx) & 4'b1) != 0) pick = idx;
                end
                if (m_job) begin
                    m_prev_id  <= m_id;
                    m_prev_res <= tri_sum(m_L);
                end
                m_rr <= rrv;
                if (pick >= 0) begin
                    m_job <= 1;
                    m_id  <= pick;
                    m_L   <= int'((req_limit >> (pick * CNT_W)) & 28'h7F);
                    m_dp  <= int'((req_limit >> (pick * CNT_W)) & 28'h7F);
                    m_t0  <= cyc;
                end else begin
                    m_job <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int d, ro, e_id, e_res;
        bit e_busy, e_ld, e_en, e_rv;
        logic [NREQ-1:0] e_ack;
        if (!rst) begin
            chk("rst_ack", 32'(ack), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_result", 32'(rsp_result), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_dp_limit", 32'(dp_limit), 0);
            chk("rst_strobes", {28'd0, ld_sum, ld_counter, en_sum, en_counter}, 0);
        end else begin
            d      = cyc - m_t0;
            ro     = resp_off(m_L);
            e_ack  = (m_job && d == 1) ? NREQ'(1 << m_id) : '0;
            e_busy = m_job && d >= 1 && d <= ro;
            e_ld   = m_job && m_L != 0 && d == 2;
            e_en   = m_job && m_L != 0 && d >= 3 && d <= m_L + 2;
            e_rv   = m_job && d == ro;
            e_id   = (m_job && d >= ro) ? m_id : m_prev_id;
            e_res  = (m_job && d >= ro) ? tri_sum(m_L) : m_prev_res;
            chk("ack", 32'(ack), 32'(e_ack));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("ld_sum", 32'(ld_sum), 32'(e_ld));
            chk("ld_counter", 32'(ld_counter), 32'(e_ld));
            chk("en_sum", 32'(en_sum), 32'(e_en));
            chk("en_counter", 32'(en_counter), 32'(e_en));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_id", 32'(rsp_id), e_id);
            chk("rsp_result", 32'(rsp_result), e_res);
            chk("dp_limit", 32'(dp_limit), m_dp);
        end
    end

    task automatic set_limit(int id, int l);
        req_limit = (req_limit & ~(28'h7F << (id * CNT_W))) | (28'(l) << (id * CNT_W));
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic run_job(int id, int l, int exp_res, int exp_lat, int new_l);
        int i, n_ld, n_en;
        bit got_ack, got_rsp;
        @(posedge clk); #1;
        set_limit(id, l);
        req = req | NREQ'(1 << id);
        n_ld = 0; n_en = 0; got_ack = 0; got_rsp = 0;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (((ack >> id) & 4'b1) != 0) begin
                got_ack = 1;
                req = req & ~NREQ'(1 << id);
            end
            if (ld_sum) n_ld++;
            if (en_sum) n_en++;
            if (new_l >= 0 && i == 6) set_limit(id, new_l);
            if (rsp_valid) begin
                got_rsp = 1;
                break;
            end
        end
        $display("[TB] job id=%0d L=%0d -> rsp_id=%0d result=%0d latency=%0d en=%0d",
                 id, l, rsp_id, rsp_result, i, n_en);
        chk("job_ack_seen", 32'(got_ack), 1);
        chk("job_rsp_seen", 32'(got_rsp), 1);
        chk("job_latency", i, exp_lat);
        chk("job_rsp_id", 32'(rsp_id), id);
        chk("job_rsp_result", 32'(rsp_result), exp_res);
        chk("job_ld_pulses", n_ld, (l == 0) ? 0 : 1);
        chk("job_en_cycles", n_en, l);
        chk("job_dp_limit", 32'(dp_limit), l);
        wait_idle();
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int ord[$];
        int res[$];
        logic [NREQ-1:0] rearm;
        int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
        int exp_fr[6]  = '{55, 210, 465, 820, 55, 210};

        // Reset held with every requester asking.
        req = 4'b1111;
        repeat (3) @(negedge clk);
        chk("reset_no_ack", 32'(ack), 0);
        chk("reset_not_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack != 0) break;
        end
        $display("[TB] first grant after reset ack=%b", ack);
        chk("first_grant", 32'(ack), 1);
        req = '0;
        wait_idle();

        run_job(2, 100, 5050, 104, -1);
        run_job(3, 1, 1, 5, -1);
        run_job(0, 127, 8128, 131, -1);
        run_job(1, 0, 0, 2, -1);

        // Fairness: all four requesting, each re-arms one cycle after its own ack.
        reset_pulse();
        @(posedge clk); #1;
        req_limit = {7'd40, 7'd30, 7'd20, 7'd10};
        req = 4'b1111;
        rearm = '0;
        for (i = 0; i < 2000 && res.size() < 6; i++) begin
            @(negedge clk);
            req = req | rearm;
            rearm = '0;
            for (int r = 0; r < NREQ; r++) begin
                if (((ack >> r) & 4'b1) != 0) begin
                    ord.push_back(r);
                    req = req & ~NREQ'(1 << r);
                    if (ord.size() < 6) rearm = rearm | NREQ'(1 << r);
                end
            end
            if (ord.size() >= 6) req = '0;
            if (rsp_valid) begin
                res.push_back(int'(rsp_result));
                $display("[TB] fair rsp id=%0d result=%0d", rsp_id, rsp_result);
            end
        end
        chk("fair_grant_count", ord.size(), 6);
        chk("fair_rsp_count", res.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("fair_order", (k < ord.size()) ? ord[k] : -1, exp_ord[k]);
            chk("fair_result", (k < res.size()) ? res[k] : -1, exp_fr[k]);
        end
        wait_idle();

        // Reset in the middle of an L=50 job.
        @(posedge clk); #1;
        set_limit(0, 50);
        req = 4'b0001;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack[0]) break;
        end
        chk("midrst_ack", 32'(ack), 1);
        req = '0;
        repeat (10) @(negedge clk);
        chk("midrst_running", 32'(en_sum), 1);
        #2;
        rst = 1'b0;
        #1;
        $display("[TB] mid-job reset busy=%0d en_sum=%0d dp_limit=%0d rsp_result=%0d",
                 busy, en_sum, dp_limit, rsp_result);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_en_sum", 32'(en_sum), 0);
        chk("midrst_dp_limit", 32'(dp_limit), 0);
        chk("midrst_rsp_result", 32'(rsp_result), 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        run_job(0, 10, 55, 14, -1);

        // Limit change while id 1 is running.
        run_job(1, 20, 210, 24, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_job_arbiter.md
Name: sum_job_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sum-accumulate datapath (controller/datapath pair of sum1to100) among NREQ requesters.
- Each requester asks for the sum 1..L for its own limit L.
- The block grants one job at a time, drives the datapath load/enable strobes, captures the result and returns it tagged with the requester id.
- It sits between the requester clients and the datapath, replacing the fixed-limit controller.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 7, width of limit and counter
RES_W, 13, width of result; RES_W must hold the sum 1..(2^CNT_W-1) (8128 at defaults)
ID_W, 2, width of requester id (clog2 NREQ)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
req  in  NREQ  request per requester; held high until ack
req_limit  in  NREQ*CNT_W  limit L per requester, slice i = bits [i*CNT_W +: CNT_W], sampled at grant
ack  out  NREQ  one-hot, 1-cycle pulse: request accepted
busy  out  1  high in every state except IDLE
rsp_valid  out  1  1-cycle pulse: result available
rsp_id  out  ID_W  requester id for rsp_result
rsp_result  out  RES_W  sum 1..L, held until next rsp_valid
dp_limit  out  CNT_W  latched limit to datapath
ld_sum  out  1  datapath: sum := 0
ld_counter  out  1  datapath: counter := 1
en_sum  out  1  datapath: sum := sum + counter
en_counter  out  1  datapath: counter := counter + 1
done  in  1  datapath, combinational: counter > dp_limit
result  in  RES_W  datapath sum register

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0; rr pointer=0; latched id/limit=0.
  - Reset mid-job aborts the job with no rsp_valid; the datapath is not cleared (the next LOAD clears it).
- FSM: IDLE, GRANT, LOAD, RUN, RESP. All outputs are registered/Moore except en_sum/en_counter.
- IDLE:
  - If any req=1, pick the first set bit searching from rr pointer upward with wrap.
  - Latch id and req_limit slice; go to GRANT.
  - If no req, stay in IDLE.
- GRANT:
  - ack[id]=1 for exactly one cycle.
  - If latched L=0, go to RESP with rsp_result:=0; ld_*/en_* are never asserted for that job.
  - Otherwise go to LOAD.
- LOAD: ld_sum=ld_counter=1 for one cycle; go to RUN.
- RUN:
  - en_sum=en_counter=(state==RUN) & ~done.
  - When done=1: enables low, capture result into rsp_result, go to RESP.
  - RUN therefore lasts L+1 cycles.
- RESP: rsp_valid=1, rsp_id=id for one cycle; rr pointer := id+1 mod NREQ; go to IDLE.
- dp_limit holds the latched limit from GRANT until the next grant.
- Latency:
  - The rsp_valid cycle is L+4 cycles after the IDLE edge that sampled req (L=100 → 104).
  - For L=0 it is 2 cycles.
  - The next grant can be sampled on the edge after RESP.
- Requester rules:
  - Requester must drop req in the cycle after its ack; req still high then counts as a new request.
  - req dropped before ack withdraws the request.
  - Changes to req_limit after grant are ignored.
- Simultaneous requests: round-robin by rr pointer; a continuously requesting id waits at most NREQ-1 jobs.
- No arithmetic inside the block except the pointer wrap. Result correctness relies on the datapath contract above.

Test Plan:
- Reset: rst=0 with req=4'b1111 → all outputs 0, no ack. After release, ack[0] is the first grant.
- Single job: req[2]=1, L=100 → ack[2] one cycle; one ld_sum/ld_counter pulse; exactly 100 en_sum cycles; rsp_valid at +104 with rsp_id=2, rsp_result=5050.
- Boundaries:
  - L=1 → rsp_result=1 at +5.
  - L=127 → 8128.
  - L=0 → rsp_result=0 at +2, no ld/en pulses.
- Fairness: all four req held (dropped after own ack, reasserted 1 cycle later) → grant order 0,1,2,3,0,1; each result matches its own limit (10, 20, 30, 40 → 55, 210, 465, 820).
- Mid-job reset: assert rst=0 during RUN of an L=50 job → outputs 0 asynchronously, no rsp_valid. After release, a new L=10 job returns 55.
- Limit change after grant: change req_limit[1] during RUN of id 1 (L=20→5) → rsp_result=210 and dp_limit stays 20.
